// File: rtl/tdc_sum_pkg.sv
// Width helpers and the accumulation-exponent clamp shared by the TDC sum tree.
package tdc_sum_pkg;

  // Width of one channel term: largest int*mult + frac must fit.
  function automatic int tw_f(input int int_w, input int frac_w, input int mult);
    longint top_v;
    top_v = ((longint'(1) << int_w) - 1) * longint'(mult) + (longint'(1) << frac_w);
    return $clog2(top_v);
  endfunction

  function automatic int sw_f(input int tw, input int n_ch);
    return tw + $clog2(n_ch);
  endfunction

  function automatic int aw_f(input int sw, input int max_k);
    return sw + max_k;
  endfunction

  function automatic logic [3:0] clamp_k(input logic [3:0] k, input int max_k);
    return (int'(k) > max_k) ? 4'(max_k) : k;
  endfunction

endpackage

// File: rtl/tdc_chan_term.sv
// One TDC channel: masked input register, then int*COARSE_MULT + frac register.
module tdc_chan_term
  import tdc_sum_pkg::*;
#(
  parameter int INT_W       = 10,
  parameter int FRAC_W      = 7,
  parameter int COARSE_MULT = 50,
  localparam int T_W        = tw_f(INT_W, FRAC_W, COARSE_MULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_in_i,
  input  logic              ld_term_i,
  input  logic              mask_i,
  input  logic [INT_W-1:0]  int_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic [T_W-1:0]    term_o
);

  logic [INT_W-1:0]  int_q;
  logic [FRAC_W-1:0] frac_q;
  logic [T_W-1:0]    term_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_q  <= '0;
      frac_q <= '0;
    end else if (ld_in_i) begin
      int_q  <= mask_i ? int_i : '0;
      frac_q <= mask_i ? frac_i : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      term_q <= '0;
    end else if (ld_term_i) begin
      term_q <= T_W'(int_q) * T_W'(COARSE_MULT) + T_W'(frac_q);
    end
  end

  assign term_o = term_q;

endmodule

// File: rtl/tdc_sum_tree.sv
// Sums scaled TDC codes of all enabled channels through a pipelined adder tree,
// then accumulates 2^k tree results into one output word plus its average.
module tdc_sum_tree
  import tdc_sum_pkg::*;
#(
  parameter int N_CH         = 16,
  parameter int INT_W        = 10,
  parameter int FRAC_W       = 7,
  parameter int COARSE_MULT  = 50,
  parameter int MAX_ACC_LOG2 = 8,
  localparam int T_W         = tw_f(INT_W, FRAC_W, COARSE_MULT),
  localparam int S_W         = sw_f(T_W, N_CH),
  localparam int A_W         = aw_f(S_W, MAX_ACC_LOG2)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_CH-1:0][INT_W-1:0]   int_data,
  input  logic [N_CH-1:0][FRAC_W-1:0]  frac_data,
  input  logic [N_CH-1:0]              ch_mask,
  input  logic [3:0]                   acc_log2,
  input  logic                         clr,
  output logic [A_W-1:0]               out_sum,
  output logic [S_W-1:0]               out_avg,
  output logic                         out_dval
);

  localparam int LV = $clog2(N_CH);
  localparam int CW = MAX_ACC_LOG2 + 1;

  logic                       v1_q, v2_q;
  logic [3:0]                 k1_q, k2_q;
  logic [N_CH-1:0][T_W-1:0]   term;

  // A start in the clr cycle is still accepted: v1 is not gated by clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      k1_q <= '0;
      k2_q <= '0;
    end else begin
      v1_q <= start;
      v2_q <= v1_q & ~clr;
      if (start) k1_q <= acc_log2;
      if (v1_q)  k2_q <= k1_q;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tdc_chan_term #(
      .INT_W       (INT_W),
      .FRAC_W      (FRAC_W),
      .COARSE_MULT (COARSE_MULT)
    ) u_term (
      .clk       (clk),
      .rst       (rst),
      .ld_in_i   (start),
      .ld_term_i (v1_q),
      .mask_i    (ch_mask[c]),
      .int_i     (int_data[c]),
      .frac_i    (frac_data[c]),
      .term_o    (term[c])
    );
  end

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int NO = N_CH >> (l + 1);
    localparam int W  = T_W + l + 1;

    logic [2*NO-1:0][W-2:0] din;
    logic                   v_in;
    logic [3:0]             k_in;
    logic [NO-1:0][W-1:0]   node_q;
    logic                   v_q;
    logic [3:0]             k_q;

    if (l == 0) begin : g_src
      assign din  = term;
      assign v_in = v2_q;
      assign k_in = k2_q;
    end else begin : g_mid
      assign din  = g_lvl[l-1].node_q;
      assign v_in = g_lvl[l-1].v_q;
      assign k_in = g_lvl[l-1].k_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        node_q <= '0;
        v_q    <= 1'b0;
        k_q    <= '0;
      end else begin
        v_q <= v_in & ~clr;
        if (v_in) begin
          k_q <= k_in;
          for (int j = 0; j < NO; j++) begin
            node_q[j] <= W'(din[2*j]) + W'(din[2*j+1]);
          end
        end
      end
    end
  end

  logic [S_W-1:0] tree_sum;
  logic           tree_v;
  logic [3:0]     tree_k;

  assign tree_sum = g_lvl[LV-1].node_q[0];
  assign tree_v   = g_lvl[LV-1].v_q;
  assign tree_k   = g_lvl[LV-1].k_q;

  logic [A_W-1:0] acc_q, acc_d, tot_q, tot_d, sum_w;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]     kg_q, kg_d, kout_q, kout_d, k_use;
  logic           done_q, done_d;

  // The group exponent is taken from the first sample only (counter at zero).
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    kg_d    = kg_q;
    tot_d   = tot_q;
    kout_d  = kout_q;
    done_d  = 1'b0;
    k_use   = (cnt_q == '0) ? clamp_k(tree_k, MAX_ACC_LOG2) : kg_q;
    sum_w   = acc_q + A_W'(tree_sum);
    cnt_inc = cnt_q + 1'b1;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (tree_v) begin
      if (cnt_inc == (CW'(1) << k_use)) begin
        done_d = 1'b1;
        tot_d  = sum_w;
        kout_d = k_use;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = sum_w;
        cnt_d = cnt_inc;
        kg_d  = k_use;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      kg_q   <= '0;
      tot_q  <= '0;
      kout_q <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      kg_q   <= kg_d;
      tot_q  <= tot_d;
      kout_q <= kout_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_sum  <= '0;
      out_avg  <= '0;
      out_dval <= 1'b0;
    end else begin
      out_dval <= done_q & ~clr;
      if (done_q && !clr) begin
        out_sum <= tot_q;
        out_avg <= S_W'(tot_q >> kout_q);
      end
    end
  end

endmodule

// File: tb/tb_tdc_sum_tree.sv
// Directed bench for tdc_sum_tree at default parameters with hand-computed results.
module tb_tdc_sum_tree;

  localparam int N_CH   = 16;
  localparam int INT_W  = 10;
  localparam int FRAC_W = 7;
  localparam int S_W    = 20;
  localparam int A_W    = 28;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        start = 1'b0;
  logic                        clr = 1'b0;
  logic [N_CH-1:0][INT_W-1:0]  int_data;
  logic [N_CH-1:0][FRAC_W-1:0] frac_data;
  logic [N_CH-1:0]             ch_mask;
  logic [3:0]                  acc_log2;
  logic [A_W-1:0]              out_sum;
  logic [S_W-1:0]              out_avg;
  logic                        out_dval;

  int n_chk = 0;
  int n_pass = 0;
  int dval_cnt = 0;

  tdc_sum_tree dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .int_data  (int_data),
    .frac_data (frac_data),
    .ch_mask   (ch_mask),
    .acc_log2  (acc_log2),
    .clr       (clr),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .out_dval  (out_dval)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_dval) dval_cnt++;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_all(input int iv, input int fv, input logic [N_CH-1:0] m);
    for (int c = 0; c < N_CH; c++) begin
      int_data[c]  = INT_W'(iv);
      frac_data[c] = FRAC_W'(fv);
    end
    ch_mask = m;
  endtask

  task automatic one_shot(input int k);
    start    = 1'b1;
    acc_log2 = 4'(k);
    step();
    start    = 1'b0;
  endtask

  task automatic wait_dval(input int max, output int steps);
    steps = 0;
    while (!out_dval && steps < max) begin
      step();
      steps++;
    end
    if (!out_dval) steps = -1;
  endtask

  task automatic expect_result(input string tag, input int lat, input longint sum, input longint avg);
    int s;
    wait_dval(lat + 6, s);
    check({tag, "_lat"}, s, lat);
    check({tag, "_sum"}, out_sum, sum);
    check({tag, "_avg"}, out_avg, avg);
    step();
    check({tag, "_pulse"}, out_dval, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    int d0;
    set_all(0, 0, '0);
    acc_log2 = '0;
    #1 rst = 1'b0;
    step(3);
    check("rst_sum", out_sum, 0);
    check("rst_avg", out_avg, 0);
    check("rst_dval", out_dval, 0);
    rst = 1'b1;
    step(2);

    set_all(1, 0, 16'hFFFF);
    one_shot(0);
    expect_result("basic", 7, 800, 800);

    set_all(1023, 127, 16'hFFFF);
    one_shot(0);
    expect_result("max", 7, 820432, 820432);

    for (int c = 0; c < N_CH; c++) begin
      int_data[c]  = INT_W'($urandom);
      frac_data[c] = FRAC_W'($urandom);
    end
    int_data[0]  = 10'd3;
    frac_data[0] = 7'd5;
    ch_mask      = 16'h0001;
    one_shot(0);
    expect_result("mask", 7, 155, 155);

    // k=2 group of four; later k values in the group must be ignored
    d0 = dval_cnt;
    set_all(1, 0, 16'hFFFF);
    start    = 1'b1;
    acc_log2 = 4'd2;
    step();
    acc_log2 = 4'd0;
    step(3);
    ch_mask      = 16'h0001;
    int_data[0]  = 10'd3;
    frac_data[0] = 7'd5;
    step();
    start = 1'b0;
    wait_dval(20, s);
    check("grp_lat", s, 6);
    check("grp_sum", out_sum, 3200);
    check("grp_avg", out_avg, 800);
    step();
    check("grp_next_dval", out_dval, 1);
    check("grp_next_sum", out_sum, 155);
    check("grp_next_avg", out_avg, 155);
    step();
    check("grp_dval_cnt", dval_cnt - d0, 2);

    // k=15 clamps to 8: 256 samples at full scale
    d0 = dval_cnt;
    set_all(1023, 127, 16'hFFFF);
    start    = 1'b1;
    acc_log2 = 4'd15;
    step();
    acc_log2 = 4'd0;
    step(255);
    start = 1'b0;
    wait_dval(20, s);
    check("clamp_lat", s, 7);
    check("clamp_sum", out_sum, 210030592);
    check("clamp_avg", out_avg, 820432);
    step();
    check("clamp_dval_cnt", dval_cnt - d0, 1);

    d0 = dval_cnt;
    set_all(1, 0, 16'hFFFF);
    one_shot(0);
    step(2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step(12);
    check("clr_no_dval", dval_cnt - d0, 0);
    check("clr_hold_sum", out_sum, 210030592);
    check("clr_hold_avg", out_avg, 820432);

    set_all(2, 1, 16'hFFFF);
    clr = 1'b1;
    start = 1'b1;
    acc_log2 = 4'd0;
    step();
    clr = 1'b0;
    start = 1'b0;
    expect_result("clr_same", 7, 1616, 1616);

    // clr must also discard a partially accumulated group
    set_all(1, 0, 16'hFFFF);
    one_shot(1);
    step(12);
    clr = 1'b1;
    step();
    clr = 1'b0;
    ch_mask      = 16'h0001;
    int_data[0]  = 10'd3;
    frac_data[0] = 7'd5;
    start    = 1'b1;
    acc_log2 = 4'd1;
    step(2);
    start = 1'b0;
    expect_result("clr_grp", 7, 310, 155);

    d0 = dval_cnt;
    set_all(1, 0, 16'hFFFF);
    start    = 1'b1;
    acc_log2 = 4'd0;
    step(2);
    start = 1'b0;
    step(2);
    rst = 1'b0;
    #1;
    check("mid_rst_sum", out_sum, 0);
    check("mid_rst_avg", out_avg, 0);
    check("mid_rst_dval", out_dval, 0);
    step(3);
    rst = 1'b1;
    step(12);
    check("mid_rst_no_dval", dval_cnt - d0, 0);
    one_shot(0);
    expect_result("post_rst", 7, 800, 800);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
